// File: rtl/accel_spi_reader.sv
// SPI mode-0 master that periodically burst-reads the accelerometer X/Y/Z registers,
// hands the three signed samples to the magnitude unit and waits for its completion.
module accel_spi_reader #(
  parameter int         CLK_DIV       = 4,
  parameter int         SAMPLE_PERIOD = 50000,
  parameter logic [7:0] START_REG     = 8'h3B
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  output logic               spi_cs_n,
  output logic               spi_sclk,
  output logic               spi_mosi,
  input  logic               spi_miso,
  output logic signed [15:0] x_out,
  output logic signed [15:0] y_out,
  output logic signed [15:0] z_out,
  output logic               start,
  input  logic               mag_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int                DIV_W        = $clog2(CLK_DIV);
  localparam int                TICK_W       = $clog2(SAMPLE_PERIOD);
  localparam logic [DIV_W-1:0]  DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(SAMPLE_PERIOD - 1);
  localparam logic [7:0]        CMD          = {1'b1, START_REG[6:0]};
  localparam logic [5:0]        LAST_BIT     = 6'd55;
  localparam logic [5:0]        FIRST_RX_BIT = 6'd8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    ISSUE,
    WAIT_MAG
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [TICK_W-1:0]   tick_cnt_q;
  logic                tick;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    div_d;
  logic                div_last;
  logic [5:0]          bit_q;
  logic [5:0]          bit_d;
  logic [7:0]          cmd_q;
  logic [7:0]          cmd_d;
  logic [47:0]         rx_q;
  logic [47:0]         rx_d;
  logic                cs_n_d;
  logic                sclk_d;
  logic                mosi_d;
  logic                start_d;
  logic                busy_d;
  logic                overrun_d;
  logic signed [15:0]  x_d;
  logic signed [15:0]  y_d;
  logic signed [15:0]  z_d;

  // Sample tick: the counter is parked at zero while disabled, so a tick that is
  // already due in the cycle enable falls is still honoured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q <= '0;
    end else if (!enable || tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  assign tick     = (tick_cnt_q == TICK_LAST);
  assign div_last = (div_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    cmd_d     = cmd_q;
    rx_d      = rx_q;
    cs_n_d    = spi_cs_n;
    sclk_d    = spi_sclk;
    mosi_d    = spi_mosi;
    start_d   = 1'b0;
    busy_d    = busy;
    overrun_d = tick && (state_q != IDLE);
    x_d       = x_out;
    y_d       = y_out;
    z_d       = z_out;

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
          mosi_d  = CMD[7];
          cmd_d   = {CMD[6:0], 1'b0};
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
        end
      end

      SETUP: begin
        div_d = div_q + 1'b1;
        if (div_last) begin
          state_d = XFER;
          sclk_d  = 1'b1;
          div_d   = '0;
        end
      end

      XFER: begin
        div_d = div_q + 1'b1;
        if (div_last) begin
          div_d  = '0;
          sclk_d = ~spi_sclk;
          if (spi_sclk) begin
            // Falling edge: shift the next command bit out; zeros follow the command byte.
            mosi_d = cmd_q[7];
            cmd_d  = {cmd_q[6:0], 1'b0};
            if (bit_q == LAST_BIT) begin
              state_d = HOLD;
            end else begin
              bit_d = bit_q + 6'd1;
            end
          end else if (bit_q >= FIRST_RX_BIT) begin
            rx_d = {rx_q[46:0], spi_miso};
          end
        end
      end

      HOLD: begin
        div_d = div_q + 1'b1;
        if (div_last) begin
          state_d = ISSUE;
          div_d   = '0;
          cs_n_d  = 1'b1;
          start_d = 1'b1;
          x_d     = $signed(rx_q[47:32]);
          y_d     = $signed(rx_q[31:16]);
          z_d     = $signed(rx_q[15:0]);
        end
      end

      ISSUE: begin
        state_d = WAIT_MAG;
      end

      WAIT_MAG: begin
        if (mag_valid) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      cmd_q    <= '0;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      start    <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      x_out    <= '0;
      y_out    <= '0;
      z_out    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      cmd_q    <= cmd_d;
      spi_cs_n <= cs_n_d;
      spi_sclk <= sclk_d;
      spi_mosi <= mosi_d;
      start    <= start_d;
      busy     <= busy_d;
      overrun  <= overrun_d;
      x_out    <= x_d;
      y_out    <= y_d;
      z_out    <= z_d;
    end
  end

  // Receive shift register is pure data; it is fully refilled before every use.
  always_ff @(posedge clk) begin
    rx_q <= rx_d;
  end

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: SPI slave and magnitude-unit models, directed and random sample sets.
module tb_accel_spi_reader;

  localparam int CD       = 2;
  localparam int SP       = 400;
  localparam int XFER_LEN = 113 * CD;

  logic               clk       = 1'b0;
  logic               reset_n   = 1'b0;
  logic               enable    = 1'b0;
  logic               spi_miso  = 1'b0;
  logic               mag_valid = 1'b0;
  logic               spi_cs_n;
  logic               spi_sclk;
  logic               spi_mosi;
  logic signed [15:0] x_out;
  logic signed [15:0] y_out;
  logic signed [15:0] z_out;
  logic               start;
  logic               busy;
  logic               overrun;

  accel_spi_reader #(
    .CLK_DIV      (CD),
    .SAMPLE_PERIOD(SP),
    .START_REG    (8'h3B)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .x_out    (x_out),
    .y_out    (y_out),
    .z_out    (z_out),
    .start    (start),
    .mag_valid(mag_valid),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  int checks = 0;
  int errors = 0;

  // Stimulus-side state shared with the models
  logic [47:0]        slave_data = '0;
  logic signed [15:0] exp_x = '0, exp_y = '0, exp_z = '0;
  bit                 modchk   = 1'b0;
  bit                 mag_auto = 1'b1;
  int                 mag_delay = 3;
  int                 mag_at    = 0;

  // Observations collected by the monitor
  int          cs_falls = 0, starts = 0, ovr_cnt = 0;
  int          cs_fall_cyc = 0, last_ovr_cyc = 0, rise_cnt = 0, viol = 0, run = 0;
  longint      mag_result = 0;
  logic [55:0] mosi_cap = '0, slave_sr = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic longint isqrt(input longint v);
    longint lo = 0, hi = 65536, mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else                hi = mid - 1;
    end
    return lo;
  endfunction

  // SPI slave, protocol monitor and magnitude-unit model, evaluated at each falling clk edge.
  initial begin
    logic cs_p, sclk_p, mosi_p, mv_p, start_p, ovr_p;
    bit   pend;
    int   pend_cnt;
    cs_p = 1'b1; sclk_p = 1'b0; mosi_p = 1'b0; mv_p = 1'b0; start_p = 1'b0; ovr_p = 1'b0;
    pend = 1'b0; pend_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        cs_p = 1'b1; sclk_p = 1'b0; mosi_p = 1'b0; mv_p = 1'b0; start_p = 1'b0; ovr_p = 1'b0;
        pend = 1'b0; mag_valid = 1'b0; spi_miso = 1'b0; run = 0;
      end else begin
        run++;
        if (spi_cs_n && spi_sclk) viol++;
        if (cs_p && !spi_cs_n) begin
          cs_falls++;
          cs_fall_cyc = cyc;
          rise_cnt    = 0;
          viol        = 0;
          run         = 0;
          mosi_cap    = '0;
          slave_sr    = {8'h00, slave_data};
          spi_miso    = slave_sr[55];
          if (modchk) chk("cs_fall_on_tick", 64'(cyc % SP), 64'd0);
        end else if (!cs_p && spi_cs_n) begin
          if (run != CD) viol++;
          run = 0;
        end else if (!spi_cs_n) begin
          if (sclk_p != spi_sclk) begin
            if (run != CD) viol++;
            run = 0;
            if (spi_sclk) begin
              if (mosi_p != spi_mosi) viol++;
              rise_cnt++;
              mosi_cap = {mosi_cap[54:0], spi_mosi};
            end else begin
              slave_sr = {slave_sr[54:0], 1'b0};
              spi_miso = slave_sr[55];
            end
          end else if (mosi_p != spi_mosi) begin
            viol++;
          end
        end

        if (start_p) chk("start_width", 64'(start), 64'd0);
        if (start) begin
          starts++;
          chk("start_latency", 64'(cyc - cs_fall_cyc), 64'(XFER_LEN));
          chk("cs_high_at_start", 64'(spi_cs_n), 64'd1);
          chk("sclk_periods", 64'(rise_cnt), 64'd56);
          chk("spi_timing_viol", 64'(viol), 64'd0);
          chk("mosi_cmd", 64'(mosi_cap[55:48]), 64'hBB);
          chk("mosi_tail_zero", 64'(mosi_cap[47:0]), 64'd0);
          chk("x_out", 64'(x_out), 64'(exp_x));
          chk("y_out", 64'(y_out), 64'(exp_y));
          chk("z_out", 64'(z_out), 64'(exp_z));
          mag_result = isqrt(longint'(x_out) * x_out + longint'(y_out) * y_out
                             + longint'(z_out) * z_out);
          pend     = 1'b1;
          pend_cnt = mag_delay;
        end

        if (ovr_p) chk("overrun_width", 64'(overrun), 64'd0);
        if (overrun) begin
          ovr_cnt++;
          last_ovr_cyc = cyc;
        end

        if (mv_p) chk("busy_drop", 64'(busy), 64'd0);
        mag_valid = 1'b0;
        if (pend) begin
          if (mag_auto ? (pend_cnt == 0) : (cyc == mag_at)) begin
            chk("busy_before_valid", 64'(busy), 64'd1);
            mag_valid = 1'b1;
            pend      = 1'b0;
          end else if (pend_cnt > 0) begin
            pend_cnt--;
          end
        end

        cs_p    = spi_cs_n;
        sclk_p  = spi_sclk;
        mosi_p  = spi_mosi;
        mv_p    = mag_valid;
        start_p = start;
        ovr_p   = overrun;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_bytes(input logic [47:0] d);
    slave_data = d;
    exp_x      = d[47:32];
    exp_y      = d[31:16];
    exp_z      = d[15:0];
  endtask

  task automatic wait_falls(input int target, input string tag);
    int i = 0;
    while (cs_falls < target && i < 3 * SP) begin step(); i++; end
    chk(tag, 64'(cs_falls >= target), 64'd1);
  endtask

  task automatic wait_starts(input int target, input string tag);
    int i = 0;
    while (starts < target && i < 3 * SP) begin step(); i++; end
    chk(tag, 64'(starts >= target), 64'd1);
  endtask

  task automatic wait_cycle(input int target);
    int i = 0;
    while (cyc < target && i < 6 * SP) begin step(); i++; end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cs_n"},    64'(spi_cs_n), 64'd1);
    chk({tag, "_sclk"},    64'(spi_sclk), 64'd0);
    chk({tag, "_mosi"},    64'(spi_mosi), 64'd0);
    chk({tag, "_x"},       64'(x_out),    64'd0);
    chk({tag, "_y"},       64'(y_out),    64'd0);
    chk({tag, "_z"},       64'(z_out),    64'd0);
    chk({tag, "_start"},   64'(start),    64'd0);
    chk({tag, "_busy"},    64'(busy),     64'd0);
    chk({tag, "_overrun"}, 64'(overrun),  64'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int f0, f1, s0, k, e, n;
    step(3);
    check_reset_vals("reset");

    // Directed sample 01 00 FF 38 40 00
    enable = 1'b1;
    set_bytes(48'h0100_FF38_4000);
    reset_n = 1'b1;
    modchk  = 1'b1;
    wait_falls(1, "first_fall_seen");
    chk("first_fall_cycle", 64'(cs_fall_cyc), 64'(SP));
    f0 = cs_fall_cyc;
    wait_starts(1, "start1_seen");
    chk("x_directed", 64'(x_out), 64'h0100);
    chk("y_directed", 64'(y_out), 64'hFFFF_FFFF_FFFF_FF38);
    chk("z_directed", 64'(z_out), 64'h4000);

    // 3-4-0 triangle through the magnitude model
    set_bytes(48'h0003_0004_0000);
    wait_starts(2, "start2_seen");
    chk("next_fall_one_period", 64'(cs_fall_cyc), 64'(f0 + SP));
    step(mag_delay + 3);
    chk("magnitude_345", 64'(mag_result), 64'd5);
    chk("busy_after_mag", 64'(busy), 64'd0);

    // Random sample sets with random magnitude latency
    for (int t = 0; t < 5; t++) begin
      mag_delay = $urandom_range(1, 40);
      set_bytes({16'($urandom), 32'($urandom)});
      wait_starts(3 + t, "rand_start_seen");
    end

    // Magnitude unit stalls for two periods, then completes in a tick cycle
    step(mag_delay + 2);
    mag_auto = 1'b0;
    mag_at   = 32'h7FFF_FFFF;
    set_bytes({16'($urandom), 32'($urandom)});
    n = starts;
    wait_starts(n + 1, "stall_start_seen");
    k      = cs_fall_cyc / SP;
    f0     = cs_falls;
    s0     = ovr_cnt;
    mag_at = (k + 3) * SP - 1;
    wait_cycle(mag_at - 2);
    chk("overruns_while_stalled", 64'(ovr_cnt - s0), 64'd2);
    chk("no_cs_while_stalled", 64'(cs_falls), 64'(f0));
    chk("busy_while_stalled", 64'(busy), 64'd1);
    wait_cycle(mag_at + 2);
    chk("tick_with_valid_overrun", 64'(ovr_cnt - s0), 64'd3);
    chk("overrun_cycle", 64'(last_ovr_cyc), 64'(mag_at + 1));
    chk("busy_released", 64'(busy), 64'd0);
    chk("no_cs_on_valid_tick", 64'(cs_falls), 64'(f0));
    mag_auto  = 1'b1;
    mag_delay = 4;
    set_bytes({16'($urandom), 32'($urandom)});
    wait_falls(f0 + 1, "resume_fall_seen");
    chk("resume_fall_cycle", 64'(cs_fall_cyc), 64'((k + 4) * SP));
    wait_starts(n + 2, "resume_start_seen");

    // Enable dropped mid-transfer: transfer still completes, then silence
    modchk = 1'b0;
    set_bytes({16'($urandom), 32'($urandom)});
    f0 = cs_falls;
    n  = starts;
    wait_falls(f0 + 1, "en_fall_seen");
    step(20);
    enable = 1'b0;
    wait_starts(n + 1, "en_start_seen");
    step(3 * SP);
    chk("no_cs_while_disabled", 64'(cs_falls), 64'(f0 + 1));
    chk("idle_busy_disabled", 64'(busy), 64'd0);

    // Enable falling in the tick cycle still honours that tick
    set_bytes({16'($urandom), 32'($urandom)});
    f1     = cs_falls;
    n      = starts;
    enable = 1'b1;
    e      = cyc;
    wait_cycle(e + SP - 1);
    enable = 1'b0;
    wait_falls(f1 + 1, "tick_edge_fall_seen");
    chk("tick_edge_fall_cycle", 64'(cs_fall_cyc), 64'(e + SP));
    wait_starts(n + 1, "tick_edge_start_seen");
    step(2 * SP);
    chk("tick_edge_single", 64'(cs_falls), 64'(f1 + 1));

    // Reset in the middle of bit 20
    enable = 1'b1;
    set_bytes({16'($urandom), 32'($urandom)});
    f0 = cs_falls;
    s0 = starts;
    wait_falls(f0 + 1, "rst_fall_seen");
    begin
      int i = 0;
      while (rise_cnt < 20 && i < 200) begin step(); i++; end
    end
    chk("reached_bit20", 64'(rise_cnt), 64'd20);
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    step(3);
    reset_n = 1'b1;
    modchk  = 1'b1;
    wait_falls(f0 + 2, "post_rst_fall_seen");
    chk("post_rst_fall_cycle", 64'(cs_fall_cyc), 64'(SP));
    chk("no_start_from_abort", 64'(starts), 64'(s0));
    wait_starts(s0 + 1, "post_rst_start_seen");
    step(mag_delay + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
